// File: rtl/wind_gen.sv
// rtl/wind_gen.sv - parametrised wind-pattern generator for the obstacle/wind layer
//
// Purpose: produces a lane pattern over LANES lanes, advancing once every
// TICK_DIV clock cycles. Modes: CALM (no wind), STEADY (centre lane),
// SWEEP (scrolling one-hot), GUST (random lane with occasional all-lane gusts).
//
// Optional feature macro: WIND_GUST_EN. When undefined, the LFSR, the gust
// state machine and its counter are compiled out, mode 11 behaves as STEADY
// and gust is tied low.
//
// Ports:
//   clk    in   1      system clock, rising edge
//   reset  in   1      asynchronous active-low reset
//   mode   in   2      00 CALM, 01 STEADY, 10 SWEEP, 11 GUST (sampled on steps)
//   out    out  LANES  registered lane pattern, bit i = wind in lane i
//   gust   out  1      registered, high while a gust is active
//   step   out  1      registered pulse, high in the cycle a new out first appears
module wind_gen #(
  parameter int         LANES    = 3,
  parameter int         TICK_DIV = 4,
  parameter int         GUST_LEN = 3,
  parameter logic [7:0] SEED     = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  output logic [LANES-1:0] out,
  output logic             gust,
  output logic             step
);

  localparam int PW = $clog2(LANES);
  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] MID  = PW'(LANES / 2);
  localparam logic [PW-1:0] LAST = PW'(LANES - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  localparam logic [1:0] M_CALM   = 2'b00;
  localparam logic [1:0] M_STEADY = 2'b01;
  localparam logic [1:0] M_SWEEP  = 2'b10;

  function automatic logic [LANES-1:0] onehot(input logic [PW-1:0] p);
    onehot = {{(LANES-1){1'b0}}, 1'b1} << p;
  endfunction

  logic [DW-1:0]    div_cnt;
  logic [PW-1:0]    pos;
  logic [PW-1:0]    pos_nxt;
  logic [LANES-1:0] out_nxt;
  logic             tick;

  assign tick = (div_cnt == DIV_LAST);

`ifdef WIND_GUST_EN
  localparam int GW = $clog2(GUST_LEN + 1);
  localparam logic [GW-1:0] GCNT_INIT = GW'(GUST_LEN - 1);
  localparam logic [0:0] G_IDLE = 1'b0;
  localparam logic [0:0] G_BLOW = 1'b1;
  localparam logic [1:0] M_GUST = 2'b11;

  logic [7:0]    lfsr;
  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [GW-1:0] gcnt;
  logic [GW-1:0] gcnt_nxt;
  logic          gust_nxt;
  logic          fb;
  logic [6:0]    pick_wide;
  logic [PW-1:0] pick;

  // Taps for x^8+x^6+x^5+x^4+1 in a left-shifting Fibonacci register.
  assign fb        = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign pick_wide = lfsr[7:1] % 7'(LANES);
  assign pick      = PW'(pick_wide);
`endif

  always_comb begin
    pos_nxt = pos;
    out_nxt = out;
`ifdef WIND_GUST_EN
    state_nxt = state;
    gcnt_nxt  = gcnt;
    gust_nxt  = gust;
`endif
    case (mode)
      M_CALM: begin
        out_nxt = '0;
      end
      M_STEADY: begin
        pos_nxt = MID;
        out_nxt = onehot(MID);
      end
      M_SWEEP: begin
        pos_nxt = (pos == LAST) ? '0 : pos + PW'(1);
        out_nxt = onehot(pos_nxt);
      end
      default: begin
`ifdef WIND_GUST_EN
        if (state == G_BLOW && gcnt != '0) begin
          gcnt_nxt = gcnt - GW'(1);
          out_nxt  = '1;
          gust_nxt = 1'b1;
        end else if (lfsr[1:0] == 2'b11) begin
          // Reached from idle or from the last blow step: the idle rule
          // applies in the same step, so a new gust may start back-to-back.
          state_nxt = G_BLOW;
          gcnt_nxt  = GCNT_INIT;
          out_nxt   = '1;
          gust_nxt  = 1'b1;
        end else begin
          state_nxt = G_IDLE;
          gust_nxt  = 1'b0;
          pos_nxt   = pick;
          out_nxt   = onehot(pick);
        end
`else
        pos_nxt = MID;
        out_nxt = onehot(MID);
`endif
      end
    endcase
`ifdef WIND_GUST_EN
    // Leaving GUST mode aborts any gust in progress.
    if (mode != M_GUST) begin
      state_nxt = G_IDLE;
      gust_nxt  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      step    <= 1'b0;
      out     <= '0;
      pos     <= MID;
`ifdef WIND_GUST_EN
      lfsr  <= SEED;
      state <= G_IDLE;
      gcnt  <= '0;
      gust  <= 1'b0;
`endif
    end else begin
      step    <= tick;
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
      if (tick) begin
        out <= out_nxt;
        pos <= pos_nxt;
`ifdef WIND_GUST_EN
        lfsr  <= {lfsr[6:0], fb};
        state <= state_nxt;
        gcnt  <= gcnt_nxt;
        gust  <= gust_nxt;
`endif
      end
    end
  end

`ifndef WIND_GUST_EN
  assign gust = 1'b0;
`endif

endmodule

// File: tb/tb_wind_gen.sv
// tb/tb_wind_gen.sv - self-checking bench for wind_gen
module tb_wind_gen;
  localparam int         LANES    = 3;
  localparam int         TICK_DIV = 4;
  localparam int         GUST_LEN = 3;
  localparam logic [7:0] SEED     = 8'hA5;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] mode  = 2'b01;
  logic [2:0] out;
  logic       gust;
  logic       step;

  int total = 0;
  int bad   = 0;

  wind_gen #(.LANES(LANES), .TICK_DIV(TICK_DIV), .GUST_LEN(GUST_LEN), .SEED(SEED)) dut (
    .clk(clk), .reset(reset), .mode(mode), .out(out), .gust(gust), .step(step)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] out; logic gust; } exp_t;
  typedef struct { logic [1:0] mode; logic [2:0] out; logic gust; bit glitch; } vec_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, req, $time);
    end
  endtask

  // Reference model of the step behaviour.
  logic [7:0] m_lfsr;
  logic [1:0] m_pos;
  int         m_left;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic model_reset();
    m_lfsr = SEED;
    m_pos  = 2'd1;
    m_left = 0;
  endtask

  task automatic model_step(input logic [1:0] m, output exp_t e);
    e.gust = 1'b0;
    e.out  = 3'b000;
    case (m)
      2'b00: e.out = 3'b000;
      2'b01: begin m_pos = 2'd1; e.out = 3'b010; end
      2'b10: begin
        m_pos = (m_pos == 2'd2) ? 2'd0 : m_pos + 2'd1;
        e.out = 3'b001 << m_pos;
      end
      default: begin
`ifdef WIND_GUST_EN
        if (m_left > 0) begin
          m_left--;
          e.out = 3'b111; e.gust = 1'b1;
        end else if (m_lfsr[1:0] == 2'b11) begin
          m_left = GUST_LEN - 1;
          e.out = 3'b111; e.gust = 1'b1;
        end else begin
          m_pos = 2'(int'(m_lfsr[7:1]) % LANES);
          e.out = 3'b001 << m_pos;
        end
`else
        m_pos = 2'd1; e.out = 3'b010;
`endif
      end
    endcase
    if (m != 2'b11) m_left = 0;
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  // Drives one step period; expected result is queued for the monitor.
  task automatic run_step(input logic [1:0] m, input bit use_tab, input logic [2:0] t_out,
                          input logic t_gust, input bit glitch);
    exp_t e;
    logic [2:0] prev;
    prev = out;
    mode = m;
    model_step(m, e);
    if (use_tab) begin e.out = t_out; e.gust = t_gust; end
    sb.push_back(e);
    for (int i = 1; i <= TICK_DIV; i++) begin
      @(posedge clk); @(negedge clk);
      if (glitch && i == 1) mode = (m == 2'b00) ? 2'b01 : 2'b00;
      if (glitch && i == 2) mode = m;
      if (i < TICK_DIV) begin
        check("step_low", step, 0);
        check("out_hold", out, prev);
      end else begin
        check("step_high", step, 1);
      end
    end
  endtask

  logic mon_en = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en && reset && step) begin
      if (sb.size() == 0) begin
        check("unexpected_step", 1, 0);
      end else begin
        e = sb.pop_front();
        check("out", out, e.out);
        check("gust", gust, e.gust);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tab[9];
    int   glen;
    int   tries;

    tab[0] = '{2'b01, 3'b010, 1'b0, 1'b0};
    tab[1] = '{2'b10, 3'b100, 1'b0, 1'b0};
    tab[2] = '{2'b10, 3'b001, 1'b0, 1'b0};
    tab[3] = '{2'b10, 3'b010, 1'b0, 1'b0};
    tab[4] = '{2'b10, 3'b100, 1'b0, 1'b0};
    tab[5] = '{2'b00, 3'b000, 1'b0, 1'b0};
    tab[6] = '{2'b10, 3'b001, 1'b0, 1'b0};
    tab[7] = '{2'b01, 3'b010, 1'b0, 1'b0};
    tab[8] = '{2'b01, 3'b010, 1'b0, 1'b1};

    model_reset();
    repeat (3) @(negedge clk);
    check("rst_out", out, 0);
    check("rst_gust", gust, 0);
    check("rst_step", step, 0);
    reset  = 1'b1;
    mon_en = 1'b1;

    foreach (tab[i]) run_step(tab[i].mode, 1'b1, tab[i].out, tab[i].gust, tab[i].glitch);

    // Asynchronous reset mid-sweep.
    run_step(2'b10, 1'b1, 3'b100, 1'b0, 1'b0);
    mode = 2'b10;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("async_out", out, 0);
    check("async_gust", gust, 0);
    check("async_step", step, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    run_step(2'b10, 1'b1, 3'b100, 1'b0, 1'b0);
    run_step(2'b10, 1'b1, 3'b001, 1'b0, 1'b0);

`ifdef WIND_GUST_EN
    glen = 0;
    for (int i = 0; i < 20; i++) begin
      run_step(2'b11, 1'b0, 3'b000, 1'b0, 1'b0);
      if (gust) glen++;
      else begin
        if (glen != 0) check("gust_len_mod", 8'(glen % GUST_LEN), 0);
        glen = 0;
        check("idle_onehot", 8'($onehot(out)), 1);
      end
    end

    // Abort a gust by switching to CALM.
    tries = 0;
    do begin
      run_step(2'b11, 1'b0, 3'b000, 1'b0, 1'b0);
      tries++;
    end while (m_left == 0 && tries < 40);
    check("gust_found", 8'(m_left > 0), 1);
    run_step(2'b00, 1'b1, 3'b000, 1'b0, 1'b0);

    // Asynchronous reset mid-gust.
    tries = 0;
    do begin
      run_step(2'b11, 1'b0, 3'b000, 1'b0, 1'b0);
      tries++;
    end while (m_left == 0 && tries < 40);
    check("gust_found2", 8'(m_left > 0), 1);
    mode = 2'b11;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("async_gust_out", out, 0);
    check("async_gust_gust", gust, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) run_step(2'b11, 1'b0, 3'b000, 1'b0, 1'b0);
`else
    for (int i = 0; i < 6; i++) begin
      run_step(2'b11, 1'b1, 3'b010, 1'b0, 1'b0);
      check("nogust_gust", gust, 0);
    end
    run_step(2'b10, 1'b1, 3'b100, 1'b0, 1'b0);
    run_step(2'b11, 1'b1, 3'b010, 1'b0, 1'b0);
`endif

    @(negedge clk);
    check("sb_empty", 8'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
